// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings used by the memory stage.
//   ResultSrc encodings  : selects the value the Writeback stage commits
//   funct3 encodings     : size/sign of a load or store
//   memState_t           : memory-stage access FSM states
package riscv_pkg;

    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;
    localparam logic [2:0] RES_IMM = 3'b011;
    localparam logic [2:0] RES_PCT = 3'b100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/memory_cycle_data_mem.sv
// Data memory for the M stage: 2^DM_AW 32-bit words.
//   CLK   : clock
//   WE    : write strobe (one edge per store)
//   BE    : byte-lane enables, bit n writes WData[8n+7:8n]
//   Addr  : word index
//   WData : lane-replicated store data
//   RData : combinational read of the addressed word
// No reset: contents survive Rst and start undefined.
module data_mem #(
    parameter int DM_AW = 10
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [3:0]       BE,
    input  logic [DM_AW-1:0] Addr,
    input  logic [31:0]      WData,
    output logic [31:0]      RData
);

    logic [31:0] mem [2**DM_AW];

    always_ff @(posedge CLK) begin
        if (WE) begin
            for (int i = 0; i < 4; i++) begin
                if (BE[i]) mem[Addr][8*i +: 8] <= WData[8*i +: 8];
            end
        end
    end

    assign RData = mem[Addr];

endmodule

// File: rtl/memory_cycle.sv
// M stage of the 5-stage RV32I pipeline plus the M/W pipeline register.
//   CLK, Rst (async, active-low)
//   Inputs from E/M : RegWriteM, MemWriteM, ResultSrcM, DexControlM, RD_M,
//                     ALU_ResultM (address), WriteDataM, PCPlus4M, PCTargetM, Imm_Ext_M
//   StallM          : hold request to the hazard unit while an access waits
//   MisalignM       : illegal/misaligned access was dropped this cycle
//   M/W outputs     : RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW,
//                     PCPlus4W, PCTargetW, Imm_Ext_W
// Access FSM:
//   state    | meaning
//   MEM_IDLE | new instruction in M; completes now unless a legal access needs wait cycles
//   MEM_WAIT | access in flight; completes when cnt reaches 0
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int DM_AW   = 10,
    parameter int MEM_LAT = 0
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [2:0]  ResultSrcM,
    input  logic [2:0]  DexControlM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] PCTargetM,
    input  logic [31:0] Imm_Ext_M,
    output logic        StallM,
    output logic        MisalignM,
    output logic        RegWriteW,
    output logic [2:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] PCTargetW,
    output logic [31:0] Imm_Ext_W
);

    memState_t   state;
    logic [2:0]  cnt;
    logic        memAcc;
    logic        legal;
    logic        illegal;
    logic        needWait;
    logic        complete;
    logic        memWe;
    logic [3:0]  byteEn;
    logic [31:0] storeData;
    logic [31:0] rdWord;
    logic [31:0] rdShift;
    logic [15:0] rdHalf;
    logic [31:0] loadData;

    assign memAcc = MemWriteM | (ResultSrcM == RES_MEM);

    always_comb begin
        legal = 1'b0;
        case (DexControlM)
            F3_B:  legal = 1'b1;
            F3_BU: legal = ~MemWriteM;
            F3_H:  legal = ~ALU_ResultM[0];
            F3_HU: legal = ~ALU_ResultM[0] & ~MemWriteM;
            F3_W:  legal = (ALU_ResultM[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign illegal  = memAcc & ~legal;
    assign needWait = (MEM_LAT > 0) && memAcc && legal;

    // An instruction finishes either straight out of IDLE or on the last WAIT cycle.
    assign complete = (state == MEM_IDLE) ? ~needWait : (cnt == 3'd0);

    // Gated with Rst so the flags read 0 while reset is held.
    assign StallM    = Rst & ~complete;
    assign MisalignM = Rst & illegal & (state == MEM_IDLE);

    always_comb begin
        byteEn    = 4'b0000;
        storeData = WriteDataM;
        case (DexControlM)
            F3_B: begin
                byteEn    = 4'b0001 << ALU_ResultM[1:0];
                storeData = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                byteEn    = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{WriteDataM[15:0]}};
            end
            default: byteEn = 4'b1111;
        endcase
    end

    assign memWe = Rst & MemWriteM & legal & complete;

    data_mem #(.DM_AW(DM_AW)) u_dmem (
        .CLK   (CLK),
        .WE    (memWe),
        .BE    (byteEn),
        .Addr  (ALU_ResultM[DM_AW+1:2]),
        .WData (storeData),
        .RData (rdWord)
    );

    assign rdShift = rdWord >> {ALU_ResultM[1:0], 3'b000};
    assign rdHalf  = ALU_ResultM[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        case (DexControlM)
            F3_B:    loadData = {{24{rdShift[7]}}, rdShift[7:0]};
            F3_BU:   loadData = {24'd0, rdShift[7:0]};
            F3_H:    loadData = {{16{rdHalf[15]}}, rdHalf};
            F3_HU:   loadData = {16'd0, rdHalf};
            default: loadData = rdWord;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state <= MEM_IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (needWait) begin
                        state <= MEM_WAIT;
                        cnt   <= 3'(MEM_LAT - 1);
                    end
                end
                MEM_WAIT: begin
                    if (cnt == 3'd0) state <= MEM_IDLE;
                    else             cnt   <= cnt - 3'd1;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= RES_ALU;
            RD_W        <= 5'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            PCPlus4W    <= 32'd0;
            PCTargetW   <= 32'd0;
            Imm_Ext_W   <= 32'd0;
        end else if (complete) begin
            RegWriteW   <= RegWriteM & ~illegal;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= loadData;
            PCPlus4W    <= PCPlus4M;
            PCTargetW   <= PCTargetM;
            Imm_Ext_W   <= Imm_Ext_M;
        end else begin
            // Bubble into W while the access is still waiting.
            RegWriteW   <= 1'b0;
            ResultSrcW  <= RES_ALU;
            RD_W        <= 5'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            PCPlus4W    <= 32'd0;
            PCTargetW   <= 32'd0;
            Imm_Ext_W   <= 32'd0;
        end
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- M stage of the 5-stage RV32I pipeline; sits directly downstream of the Execute stage's E/M register.
- Owns the data memory: store byte-lane merging, load byte/half extraction with sign/zero extension, misalignment detection, and a configurable-latency access FSM that stalls the pipeline.
- Registers everything the Writeback stage needs into the M/W pipeline register.

Parameters:
- DM_AW, 10, data-memory word-address width (depth = 2^DM_AW 32-bit words)
- MEM_LAT, 0, extra wait cycles per load/store (0..7); 0 = single-cycle access

Ports:
- CLK  in  1  clock
- Rst  in  1  reset, asynchronous, active-low
- RegWriteM  in  1  register write enable from E/M register
- MemWriteM  in  1  store request
- ResultSrcM  in  3  result select: 000 ALU, 001 load data, 010 PC+4, 011 Imm, 100 PCTarget
- DexControlM  in  3  access funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  in  5  destination register
- ALU_ResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- PCPlus4M, PCTargetM, Imm_Ext_M  in  32 each  passthrough values
- StallM  out  1  hold request to hazard unit (freeze PC, F/D, D/E, E/M)
- MisalignM  out  1  one-cycle flag: misaligned or illegal access dropped
- RegWriteW  out  1  registered write enable
- ResultSrcW  out  3  registered result select
- RD_W  out  5  registered destination
- ALU_ResultW, ReadDataW, PCPlus4W, PCTargetW, Imm_Ext_W  out  32 each  registered values

Behaviour:
- Access condition: MemAcc = MemWriteM | (ResultSrcM == 001).
- Word index = ALU_ResultM[DM_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Legality, checked combinationally in M:
  - Byte accesses are always legal.
  - H/HU require addr[0] = 0.
  - W requires addr[1:0] = 00.
  - DexControl 011/110/111 is illegal for any MemAcc. For stores, only 000/001/010 are legal.
- Illegal access:
  - MisalignM = 1 in the same cycle.
  - No stall, no memory write.
  - The W register captures the instruction with RegWriteW forced to 0.
- Store:
  - Byte enables: SB = 1 << addr[1:0], lane data WriteDataM[7:0] replicated.
  - SH = 0011 or 1100 per addr[1], data WriteDataM[15:0] replicated.
  - SW = 1111.
  - The write happens at the rising edge that completes the access, exactly once.
- Load:
  - The array is read combinationally.
  - The lane is selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
  - The result is captured into ReadDataW at the completing edge.
- FSM states: IDLE, WAIT; 3-bit counter cnt.
  - IDLE, legal MemAcc, MEM_LAT > 0: StallM = 1; go to WAIT with cnt = MEM_LAT-1; W register loads a bubble (RegWriteW = 0, ResultSrcW = 000, RD_W = 0).
  - WAIT, cnt != 0: StallM = 1; cnt decrements; W loads a bubble.
  - WAIT, cnt == 0: StallM = 0; access completes (write or read capture); W captures the real instruction; go to IDLE.
  - MEM_LAT = 0: StallM is never asserted; every instruction completes in one cycle.
- Upstream obligation: inputs stay stable while StallM = 1. The hazard unit gates the E/M register with StallM, so a stalled instruction completes exactly once.
- Non-memory instructions complete in IDLE in one cycle. A non-memory instruction can never be present in WAIT.
- M/W register passthroughs, captured on every completing edge: ALU_ResultW, PCPlus4W, PCTargetW, Imm_Ext_W, RD_W, ResultSrcW, RegWriteW.
- Reset, async, including mid-WAIT:
  - FSM goes to IDLE, cnt = 0, StallM = 0, MisalignM = 0.
  - All W outputs are 0.
  - Any pending store is dropped.
  - Memory contents are not affected by Rst and are not initialised by RTL.
- Loads and stores to x0 still access memory; RegWriteW is passed through as given. The register file ignores x0.

Decomposition:
- Shared package riscv_pkg holds:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4, RES_IMM, RES_PCT).
  - DexControl/funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef.
- One sub-module, data_mem: synchronous byte-enable write, asynchronous read, parameter DM_AW.
- Lane merge, extension, legality checks, FSM and W register stay in memory_cycle.

Test Plan:
- MEM_LAT = 0:
  - SW 0xDEADBEEF @0x40, then LW @0x40 → ReadDataW = 0xDEADBEEF, RegWriteW = 1, StallM never 1.
  - SB 0x80 @0x41, then LB @0x41 → 0xFFFFFF80; LBU → 0x00000080; LW @0x40 → 0xDEAD80EF.
- MEM_LAT = 0: SH 0x1234 @0x42, then LH @0x42 → 0x00001234; then SH 0x8001 @0x42 and LH → 0xFFFF8001, LHU → 0x00008001.
- MEM_LAT = 3:
  - LW → StallM high for exactly 3 cycles, bubbles (RegWriteW = 0) during the stall, real result on the 4th edge.
  - A following ADD → W captures it with no stall.
- Misaligned: LW @0x42 and SH @0x43 → MisalignM = 1 for one cycle, RegWriteW = 0, memory @0x40 unchanged, StallM = 0. DexControl = 011 with MemWriteM = 1 → same result.
- Reset and wrap:
  - Assert Rst in WAIT during a store → StallM = 0, all W outputs 0, location unchanged.
  - With DM_AW = 10, SW @0x1000 then LW @0x0000 → same data (wrap).
